// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-indexed PC, synchronous imem, 1-entry skid, branch redirect.
module fetch_stage #(
    parameter int unsigned ADDR_W   = 11,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_valid,
    input  logic [31:0]       branch_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic              valid_out
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_FETCH  = 2'd1,
        S_STREAM = 2'd2,
        S_HOLD   = 2'd3
    } state_e;

    // Instruction word paired with the word address it came from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_word_t;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    fetch_word_t     out_q, out_d;
    logic            valid_q, valid_d;
    fetch_word_t     skid_q, skid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            rd_c;

    // State and datapath registers; reset discards in-flight and skid contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_LOAD;
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            out_q         <= '0;
            valid_q       <= 1'b0;
            skid_q        <= '0;
            skid_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            out_q         <= out_d;
            valid_q       <= valid_d;
            skid_q        <= skid_d;
            skid_valid_q  <= skid_valid_d;
        end
    end

    // Next-state and datapath control; a redirect overrides everything, including stall.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        out_d         = out_q;
        valid_d       = valid_q;
        skid_d        = skid_q;
        skid_valid_d  = skid_valid_q;
        rd_c          = 1'b0;

        if (branch_valid) begin
            pc_d         = branch_target;
            valid_d      = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
            state_d      = S_FETCH;
        end else begin
            unique case (state_q)
                S_LOAD: begin
                    pc_d    = RESET_PC;
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    // Issue the first read of a stream; a stalled valid output keeps its word.
                    rd_c          = 1'b1;
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + XLEN'(1);
                    if (!stall) begin
                        valid_d = 1'b0;
                    end
                    state_d = S_STREAM;
                end
                S_STREAM: begin
                    if (stall) begin
                        // Park the returning word; no new read until the skid drains.
                        skid_d       = '{instr: imem_rdata, pc: inflight_pc_q};
                        skid_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        out_d         = '{instr: imem_rdata, pc: inflight_pc_q};
                        valid_d       = 1'b1;
                        rd_c          = 1'b1;
                        inflight_pc_d = pc_q;
                        pc_d          = pc_q + XLEN'(1);
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        out_d        = skid_q;
                        valid_d      = skid_valid_q;
                        skid_d       = '0;
                        skid_valid_d = 1'b0;
                        state_d      = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_LOAD;
                end
            endcase
        end
    end

    // Output mapping: memory address is the low bits of the word PC.
    assign imem_addr = pc_q[ADDR_W-1:0];
    assign imem_rd   = rd_c;
    assign instr_out = out_q.instr;
    assign pc_out    = out_q.pc;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, randomized scoreboard run.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic [10:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;

    logic [10:0] w_addr;
    logic        w_rd;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pc;
    logic        w_valid;
    logic        w_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_stage #(.ADDR_W(11), .RESET_PC(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .branch_valid(branch_valid),
        .branch_target(branch_target), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_rdata(imem_rdata), .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out)
    );

    fetch_stage #(.ADDR_W(11), .RESET_PC(32'h0000_07FF)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall(w_zero), .branch_valid(w_zero),
        .branch_target(32'd0), .imem_addr(w_addr), .imem_rd(w_rd),
        .imem_rdata(w_rdata), .instr_out(w_instr), .pc_out(w_pc), .valid_out(w_valid)
    );

    // Program image: four fixed words, then an address-derived unique pattern.
    function automatic logic [31:0] mem_word(input logic [10:0] a);
        case (a)
            11'd0:   return 32'hE3A0_0001;
            11'd1:   return 32'hE3A0_100A;
            11'd2:   return 32'hE280_0001;
            11'd3:   return 32'hE150_0001;
            default: return {5'h15, a, 5'h0A, a};
        endcase
    endfunction

    // Synchronous RAM models: registered address, data one cycle later.
    always @(posedge clk) if (imem_rd) imem_rdata <= mem_word(imem_addr);
    always @(posedge clk) if (w_rd) w_rdata <= mem_word(w_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic        exp_v;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                                input logic v, input logic [31:0] p);
        vec_t r;
        r.stall = s; r.br = b; r.tgt = t; r.exp_v = v; r.exp_pc = p;
        return r;
    endfunction

    logic [10:0] w_exp_addr [3];
    logic [31:0] w_exp_pc   [3];

    logic [31:0] exp_pc;
    logic [31:0] tgt;
    logic        s, b, pv;
    int          quiet;
    int          idle;

    initial begin
        // Reset, stream, 3-cycle stall with skid + bubble, redirect, redirect during hold.
        vecs[0]  = mk(0, 0, 32'h0,  0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,  0, 32'h0);
        vecs[2]  = mk(0, 0, 32'h0,  1, 32'h0);
        vecs[3]  = mk(0, 0, 32'h0,  1, 32'h1);
        vecs[4]  = mk(1, 0, 32'h0,  1, 32'h1);
        vecs[5]  = mk(1, 0, 32'h0,  1, 32'h1);
        vecs[6]  = mk(1, 0, 32'h0,  1, 32'h1);
        vecs[7]  = mk(0, 0, 32'h0,  1, 32'h2);
        vecs[8]  = mk(0, 0, 32'h0,  0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0,  1, 32'h3);
        vecs[10] = mk(0, 0, 32'h0,  1, 32'h4);
        vecs[11] = mk(0, 1, 32'h10, 0, 32'h0);
        vecs[12] = mk(0, 0, 32'h0,  0, 32'h0);
        vecs[13] = mk(0, 0, 32'h0,  1, 32'h10);
        vecs[14] = mk(0, 0, 32'h0,  1, 32'h11);
        vecs[15] = mk(1, 0, 32'h0,  1, 32'h11);
        vecs[16] = mk(1, 1, 32'h20, 0, 32'h0);
        vecs[17] = mk(0, 0, 32'h0,  0, 32'h0);
        vecs[18] = mk(0, 0, 32'h0,  1, 32'h20);
        vecs[19] = mk(0, 0, 32'h0,  1, 32'h21);

        w_exp_addr[0] = 11'h7FF; w_exp_addr[1] = 11'h000; w_exp_addr[2] = 11'h001;
        w_exp_pc[0] = 32'h7FF;   w_exp_pc[1] = 32'h800;   w_exp_pc[2] = 32'h801;

        w_zero = 1'b0;
        rst_n = 1'b0; stall = 1'b0; branch_valid = 1'b0; branch_target = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_pc_out", pc_out, 32'd0);
        check("rst_instr", instr_out, 32'd0);
        check("rst_imem_rd", 32'(imem_rd), 32'd0);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            stall = vecs[i].stall;
            branch_valid = vecs[i].br;
            branch_target = vecs[i].tgt;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(vecs[i].exp_v));
            if (vecs[i].exp_v) begin
                check($sformatf("vec%0d_pc", i), pc_out, vecs[i].exp_pc);
                check($sformatf("vec%0d_instr", i), instr_out, mem_word(vecs[i].exp_pc[10:0]));
            end
            if (i < 3) begin
                check($sformatf("wrap_addr%0d", i), 32'(w_addr), 32'(w_exp_addr[i]));
                check($sformatf("wrap_rd%0d", i), 32'(w_rd), 32'd1);
            end
            if (i >= 2 && i < 5) begin
                check($sformatf("wrap_valid%0d", i), 32'(w_valid), 32'd1);
                check($sformatf("wrap_pc%0d", i), w_pc, w_exp_pc[i-2]);
                check($sformatf("wrap_instr%0d", i), w_instr, mem_word(w_exp_pc[i-2][10:0]));
            end
        end

        // Reset pulsed while held in a stall: outputs clear immediately, restart as power-up.
        stall = 1'b1; branch_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(valid_out), 32'd0);
        check("midrst_pc_out", pc_out, 32'd0);
        check("midrst_instr", instr_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            if (e < 3) begin
                check($sformatf("restart_e%0d_valid", e), 32'(valid_out), 32'd0);
            end else begin
                check($sformatf("restart_e%0d_valid", e), 32'(valid_out), 32'd1);
                check($sformatf("restart_e%0d_pc", e), pc_out, 32'(e - 3));
            end
        end

        // Randomized run: scoreboard tracks the next undelivered PC of the program stream.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 32'd0; quiet = 0; idle = 0;
        for (int c = 0; c < 3000; c++) begin
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 39) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom;
                1:       tgt = 32'hFFFF_FFFE;
                default: tgt = 32'($urandom_range(0, 2047));
            endcase
            stall = s; branch_valid = b; branch_target = tgt;
            pv = valid_out;
            @(posedge clk);
            #1;
            if (b) begin
                exp_pc = tgt;
                quiet = 2;
            end else if (pv && !s) begin
                exp_pc = exp_pc + 32'd1;
            end
            if (quiet > 0) begin
                check("rand_redirect_bubble", 32'(valid_out), 32'd0);
                quiet--;
            end
            if (valid_out) begin
                check("rand_pc", pc_out, exp_pc);
                check("rand_instr", instr_out, mem_word(exp_pc[10:0]));
            end
            if (!valid_out && !s && !b) idle++;
            else idle = 0;
            check("rand_progress", 32'(idle <= 2), 32'd1);
            if (c % 1000 == 999) begin
                rst_n = 1'b0;
                #1;
                check("rand_async_rst_valid", 32'(valid_out), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                exp_pc = 32'd0; quiet = 0; idle = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 11: instruction-memory word-address width.
REQ-002 Parameter RESET_PC, default 0: word address fetched first after reset.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port stall, input, 1: decode cannot accept this cycle; hold the output.
REQ-006 Port branch_valid, input, 1: redirect request from execute.
REQ-007 Port branch_target, input, 32: word address of the redirect.
REQ-008 Port imem_addr, output, ADDR_W: word address to the synchronous instruction RAM; the RAM registers it and returns data one cycle later.
REQ-009 Port imem_rd, output, 1: read strobe, high when a new address is issued.
REQ-010 Port imem_rdata, input, 32: RAM read data for the address issued in the previous cycle.
REQ-011 Port instr_out, output, 32: fetched instruction to the decode register.
REQ-012 Port pc_out, output, 32: word address of instr_out.
REQ-013 Port valid_out, output, 1: instr_out/pc_out hold a real instruction.

Function
REQ-014 PC is word-indexed and increments by 1; pc wraps modulo 2^32; imem_addr = pc[ADDR_W-1:0].
REQ-015 The FSM SHALL have states S_LOAD, S_FETCH, S_STREAM and S_HOLD.
REQ-016 S_LOAD: imem_rd=0, pc=RESET_PC; next state S_FETCH.
REQ-017 S_FETCH: imem_rd=1, imem_addr=pc; then pc<=pc+1, inflight_pc<=pc, valid_out<=0, next state S_STREAM.
REQ-018 S_STREAM without stall or redirect: register instr_out<=imem_rdata, pc_out<=inflight_pc, valid_out<=1; issue pc, inflight_pc<=pc, pc<=pc+1; stay in S_STREAM (one instruction per cycle).
REQ-019 S_STREAM with stall: outputs hold; the returning word goes to a 1-entry skid (skid_instr, skid_pc); imem_rd=0; pc holds; next state S_HOLD.
REQ-020 S_HOLD: outputs, skid and pc hold while stall=1; on the first cycle with stall=0, load outputs from the skid (valid_out=1), clear the skid, next state S_FETCH.
REQ-021 S_HOLD exit inserts exactly one valid_out=0 bubble after the skid word.
REQ-022 branch_valid has priority over stall in every state:
- pc<=branch_target; valid_out<=0; skid cleared; in-flight word discarded; imem_rd=0; next state S_FETCH.
- The first redirected instruction appears with valid_out=1 two edges after the redirect edge.
REQ-023 instr_out/pc_out SHALL NOT change while valid_out=1 and stall=1.
REQ-024 The skid depth is 1; no RAM read is issued while the skid is full.

Reset
REQ-025 rst_n=0 SHALL asynchronously set state=S_LOAD, pc=RESET_PC, valid_out=0, instr_out=0, pc_out=0, imem_rd=0, skid empty.
REQ-026 Reset asserted mid-stream or mid-hold SHALL discard all in-flight and skid data; the restart sequence is identical to power-up.
REQ-027 First valid instruction: valid_out=1 after the third rising edge following rst_n release (load, fetch, fetch-wait).

Verification
REQ-028 mem[0..3]=0xE3A00001,0xE3A0100A,0xE2800001,0xE1500001; reset, no stall -> valid_out=0 after edges 1-2; after edges 3,4,5,6: pc_out=0,1,2,3 with matching words.
REQ-029 Stall high for 3 cycles while pc_out=1 -> instr_out/pc_out hold 1 for 3 cycles; then pc_out=2 (from skid), one bubble, then pc_out=3; no word lost or duplicated.
REQ-030 branch_valid=1, branch_target=0x10 while streaming -> valid_out=0 for two cycles, then pc_out=0x10, 0x11 on consecutive cycles; no pre-branch word appears.
REQ-031 branch_valid and stall both high in S_HOLD -> skid discarded; next valid pc_out=branch_target.
REQ-032 RESET_PC=2^ADDR_W-1 -> imem_addr sequence 0x7FF, 0x000, 0x001; pc_out=0x7FF, 0x800, 0x801.
REQ-033 rst_n pulsed low mid-stall -> valid_out=0 immediately (async); restart per REQ-027 with pc_out=RESET_PC.
